// File: rtl/rgb2gray_pkg.sv
// Shared select codes, state encoding and counter width for the RGB-to-gray controller
// and its datapath.
package rgb2gray_pkg;

  localparam logic [1:0] SEL_R    = 2'd0;
  localparam logic [1:0] SEL_G    = 2'd1;
  localparam logic [1:0] SEL_B    = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MUL_R = 3'd1;
  localparam logic [2:0] ST_MUL_G = 3'd2;
  localparam logic [2:0] ST_MUL_B = 3'd3;
  localparam logic [2:0] ST_ADD   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    StIdle = ST_IDLE,
    StMulR = ST_MUL_R,
    StMulG = ST_MUL_G,
    StMulB = ST_MUL_B,
    StAdd  = ST_ADD,
    StDone = ST_DONE
  } state_e;

  localparam int unsigned CNT_W      = 4;
  localparam int unsigned SETTLE_MAX = 15;

endpackage

// File: rtl/rgb_to_gray_settle_cnt.sv
// Settle down-counter: loads a start value, counts to zero and flags the terminal count.
module rgb_to_gray_settle_cnt
  import rgb2gray_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/rgb_to_gray_ctrl.sv
// Sequencing FSM for the RGB-to-gray FP datapath behind a valid/ready pixel stream.
// Define RGB2GRAY_PIX_CNT_EN to add the completed-pixel counter output pix_count.
module rgb_to_gray_ctrl
  import rgb2gray_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned PIX_CNT_W     = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic [1:0] channel_mux,
  output logic [1:0] gain_mux,
  output logic       load_reg_en,
  output logic       r_turn_reg_en,
  output logic       g_turn_reg_en,
  output logic       b_turn_reg_en,
  output logic       result_reg_en
`ifdef RGB2GRAY_PIX_CNT_EN
  ,
  output logic [PIX_CNT_W-1:0] pix_count
`endif
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > SETTLE_MAX || PIX_CNT_W < 1) begin : g_param_check
    $error("rgb_to_gray_ctrl: SETTLE_CYCLES must be 1..15 and PIX_CNT_W >= 1");
  end

  localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYCLES - 1);

  state_e r_state, w_state_next;
  logic   r_out_valid;
  logic   w_tc;
  logic   w_cnt_load;
  logic   w_cnt_dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= (w_state_next == StDone);
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (load_reg_en) w_state_next = StMulR;
      StMulR: if (w_tc) w_state_next = StMulG;
      StMulG: if (w_tc) w_state_next = StMulB;
      StMulB: if (w_tc) w_state_next = StAdd;
      StAdd:  if (w_tc) w_state_next = StDone;
      StDone: if (out_ready) w_state_next = load_reg_en ? StMulR : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    in_ready      = 1'b0;
    busy          = 1'b0;
    channel_mux   = SEL_NONE;
    gain_mux      = SEL_NONE;
    r_turn_reg_en = 1'b0;
    g_turn_reg_en = 1'b0;
    b_turn_reg_en = 1'b0;
    result_reg_en = 1'b0;
    unique case (r_state)
      StIdle: in_ready = !rst;
      StMulR: begin
        busy          = 1'b1;
        channel_mux   = SEL_R;
        gain_mux      = SEL_R;
        r_turn_reg_en = w_tc;
      end
      StMulG: begin
        busy          = 1'b1;
        channel_mux   = SEL_G;
        gain_mux      = SEL_G;
        g_turn_reg_en = w_tc;
      end
      StMulB: begin
        busy          = 1'b1;
        channel_mux   = SEL_B;
        gain_mux      = SEL_B;
        b_turn_reg_en = w_tc;
      end
      StAdd: begin
        busy          = 1'b1;
        result_reg_en = w_tc;
      end
      // Sink acceptance frees the slot in the same cycle for back-to-back pixels.
      StDone: in_ready = !rst && out_ready;
      default: ;
    endcase
    load_reg_en = in_valid && in_ready;
  end

  assign out_valid = r_out_valid;

  // Reload on accept and on every MUL step hand-off so each step gets a full settle window.
  assign w_cnt_load = load_reg_en ||
                      (w_tc && (r_state == StMulR || r_state == StMulG || r_state == StMulB));
  assign w_cnt_dec  = busy && !w_tc;

  rgb_to_gray_settle_cnt u_settle_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (SettleLoad),
    .i_dec      (w_cnt_dec),
    .o_tc       (w_tc)
  );

`ifdef RGB2GRAY_PIX_CNT_EN
  logic [PIX_CNT_W-1:0] r_pix_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_count <= '0;
    end else if (r_out_valid && out_ready) begin
      r_pix_count <= r_pix_count + PIX_CNT_W'(1);
    end
  end

  assign pix_count = r_pix_count;
`endif

endmodule
